// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts a preset to zero at a divided rate, then pulses done.
// Define DOWNCNT_RELOAD_EN to reload the last loaded preset on expiry (periodic timer).
module down_counter_timer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIV_MAX = 49999999,
   parameter int unsigned DIV_W   = 26
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

   localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV_MAX);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             wrap;
   logic [WIDTH-1:0] wrap_val;

`ifdef DOWNCNT_RELOAD_EN
   logic [WIDTH-1:0] reload_q;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         reload_q <= '0;
      end else if (load) begin
         reload_q <= load_val;
      end
   end

   // A zero reload value falls back to the one-shot behaviour.
   assign wrap     = (reload_q != '0);
   assign wrap_val = reload_q;
`else
   assign wrap     = 1'b0;
   assign wrap_val = '0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      div_d   = div_q;
      done_d  = 1'b0;
      if (load) begin
         state_d = StIdle;
         count_d = load_val;
         div_d   = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  if (count_q != '0) begin
                     state_d = StRun;
                     div_d   = '0;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end
            end
            StRun: begin
               if (pause) begin
                  state_d = StPaused;
               end else if (div_q == DivLast) begin
                  div_d = '0;
                  if (count_q == WIDTH'(1)) begin
                     done_d = 1'b1;
                     if (wrap) begin
                        count_d = wrap_val;
                     end else begin
                        count_d = '0;
                        state_d = StDone;
                     end
                  end else if (count_q != '0) begin
                     count_d = count_q - WIDTH'(1);
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            // Divider keeps its value across the resume edge.
            StPaused: begin
               if (!pause) begin
                  state_d = StRun;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= StIdle;
         count_q <= '0;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         div_q   <= div_d;
         busy_q  <= (state_d == StRun) || (state_d == StPaused);
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized self-checking bench for down_counter_timer with a tick-count reference model.
// Honours DOWNCNT_RELOAD_EN when the design is built with it.
module tb_down_counter_timer;

   localparam int DIV_MAX = 3;
   localparam int P       = DIV_MAX + 1;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] count;
   logic       busy;
   logic       done;
   logic       zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: count = preset - floor(active_ticks / P); mode 0 idle 1 run 2 paused 3 done
   int m_mode   = 0;
   int m_preset = 0;
   int m_ticks  = 0;
   int m_reload = 0;
   bit m_done   = 0;

   down_counter_timer #(
      .WIDTH   (8),
      .DIV_MAX (DIV_MAX),
      .DIV_W   (2)
   ) dut (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   function automatic int m_count();
      return m_preset - m_ticks / P;
   endfunction

   function automatic logic [10:0] exp_vec();
      logic [7:0] c;
      logic       b;
      c = 8'(m_count());
      b = (m_mode == 1) || (m_mode == 2);
      return {c, b, logic'(m_done), logic'(c == 8'h00)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_preset = 0; m_ticks = 0; m_reload = 0; m_done = 0;
   endtask

   task automatic model_edge(input bit l, input int lv, input bit s, input bit p);
      int c;
      c = m_count();
      m_done = 0;
      if (l) begin
         m_preset = lv; m_ticks = 0; m_mode = 0; m_reload = lv;
      end else if (m_mode == 0 || m_mode == 3) begin
         if (s) begin
            if (c != 0) begin
               m_mode = 1; m_preset = c; m_ticks = 0;
            end else begin
               m_mode = 3; m_done = 1;
            end
         end
      end else if (m_mode == 1) begin
         if (p) begin
            m_mode = 2;
         end else begin
            m_ticks++;
            if (m_ticks == m_preset * P) begin
               m_done = 1;
`ifdef DOWNCNT_RELOAD_EN
               if (m_reload != 0) begin
                  m_preset = m_reload; m_ticks = 0;
               end else begin
                  m_mode = 3;
               end
`else
               m_mode = 3;
`endif
            end
         end
      end else if (!p) begin
         m_mode = 1;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
   task automatic cycle(input bit l, input int lv, input bit s, input bit p);
      load = l; load_val = lv[7:0]; start = s; pause = p;
      @(posedge clk);
      model_edge(l, lv, s, p);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      #2 clear = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({count, busy, done, zero} !== 11'b0000_0000_001) begin
         errors++;
         $display("FAIL reset_async got=%h exp=%h", {count, busy, done, zero}, 11'b0000_0000_001);
      end
      cycle(1, 8'h55, 1, 0);
      model_reset();
      checks++;
      if ({count, busy, done, zero} !== exp_vec()) begin
         errors++;
         $display("FAIL reset_held got=%h exp=%h", {count, busy, done, zero}, exp_vec());
      end
      clear = 1'b0;
   endtask

   task automatic test_countdown();
      int v, e0, dc;
      repeat (3) begin
         v = $urandom_range(1, 6);
         cycle(1, v, 0, 0);
         cycle(0, 0, 1, 0);
         e0 = cyc;
         dc = -1;
         for (int i = 0; i < v * P + 3; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if ({count, busy, done, zero} !== exp_vec()) begin
               errors++;
               $display("FAIL countdown v=%0d cyc=%0d got=%h exp=%h", v, cyc - e0,
                        {count, busy, done, zero}, exp_vec());
            end
            if (done === 1'b1 && dc < 0) dc = cyc;
         end
         checks++;
         if (dc - e0 !== v * P) begin
            errors++;
            $display("FAIL countdown_latency v=%0d got=%0d exp=%0d", v, dc - e0, v * P);
         end
      end
   endtask

   task automatic test_zero_start();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, (i == 0), 0);
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL zero_start i=%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask

   task automatic test_pause();
      int e0;
      // Directed: preset 3, pause sampled high at E0+2..E0+9
      cycle(1, 3, 0, 0);
      cycle(0, 0, 1, 0);
      e0 = cyc;
      for (int i = 1; i <= 23; i++) begin
         cycle(0, 0, 0, (i >= 2 && i <= 9));
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL pause_model e+%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
         if (i == 12 || i == 13 || i == 17 || i == 21) begin
            checks++;
            if (count !== ((i == 12) ? 8'd3 : (i == 13) ? 8'd2 : (i == 17) ? 8'd1 : 8'd0)) begin
               errors++;
               $display("FAIL pause_edge e+%0d got=%0d", i, count);
            end
         end
      end
      // Randomized pause pattern
      cycle(1, $urandom_range(2, 5), 0, 0);
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 50; i++) begin
         cycle(0, 0, 0, ($urandom_range(0, 2) == 0));
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL pause_rand i=%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask

   task automatic test_load_abort();
      cycle(1, 9, 0, 0);
      cycle(0, 0, 1, 0);
      for (int i = 1; i <= 14; i++) begin
         if (i == 6) cycle(1, 8'h42, 0, 0);
         else cycle(0, 0, (i == 9), 0);
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL load_abort e+%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask

   task automatic test_clear();
      cycle(1, 7, 0, 0);
      cycle(0, 0, 1, 0);
      repeat (9) cycle(0, 0, 0, 0);
      #3 clear = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({count, busy, done, zero} !== 11'b0000_0000_001) begin
         errors++;
         $display("FAIL clear_midrun got=%h exp=%h", {count, busy, done, zero}, 11'b0000_0000_001);
      end
      #1 clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, (i == 0), 0);
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL clear_restart i=%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask

`ifdef DOWNCNT_RELOAD_EN
   task automatic test_reload();
      cycle(1, 2, 0, 0);
      cycle(0, 0, 1, 0);
      for (int i = 1; i <= 26; i++) begin
         cycle(0, 0, 0, 0);
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL reload e+%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask
`endif

   task automatic test_random();
      bit l, s, p;
      int lv;
      for (int i = 0; i < 400; i++) begin
         l  = ($urandom_range(0, 11) == 0);
         s  = ($urandom_range(0, 4) == 0);
         p  = ($urandom_range(0, 3) == 0);
         lv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
         cycle(l, lv, s, p);
         checks++;
         if ({count, busy, done, zero} !== exp_vec()) begin
            errors++;
            $display("FAIL random i=%0d got=%h exp=%h", i, {count, busy, done, zero}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_zero_start();
      test_pause();
      test_load_abort();
      test_clear();
`ifdef DOWNCNT_RELOAD_EN
      test_reload();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
